uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 154 +++++++++++++++
 tb/tb_uart_tx_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: 8 data bits, LSB first, 1 or 2 stop bits, valid/ready byte intake.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after bit 7.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 347,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ser_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [2:0]        idx_q, idx_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic              ser_n;
  logic              bit_last, stop_last, hs;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_n;
`endif

  always_comb begin
    bit_last  = (cnt_q == CNT_LAST);
    stop_last = bit_last && (idx_q == STOP_LAST);
    tx_done   = (state_q == STOP) && stop_last;
    tx_ready  = (state_q == IDLE) || tx_done;
    tx_busy   = (state_q != IDLE);
    hs        = tx_valid && tx_ready;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = bit_last ? '0 : cnt_q + CNT_W'(1);
    idx_n   = idx_q;
    shreg_n = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (hs) begin
          state_n = START;
          shreg_n = tx_data;
`ifdef UART_TX_PARITY_EN
          par_n   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_last) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_last) begin
          shreg_n = shreg_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
            idx_n = '0;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          state_n = STOP;
          idx_n   = '0;
        end
      end
`endif
      STOP: begin
        if (stop_last) begin
          idx_n = '0;
          // A handshake on the final stop cycle chains the next frame with no idle gap
          if (hs) begin
            state_n = START;
            shreg_n = tx_data;
`ifdef UART_TX_PARITY_EN
            par_n   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
          end else begin
            state_n = IDLE;
          end
        end else if (bit_last) begin
          idx_n = idx_q + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is computed from the next state so ser_tx can be a plain register
    case (state_n)
      START:   ser_n = 1'b0;
      DATA:    ser_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  ser_n = par_n;
`endif
      default: ser_n = 1'b1;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      ser_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shreg_q <= shreg_n;
      ser_tx  <= ser_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at CLKS_PER_BIT=4; adapts frame length when UART_TX_PARITY_EN is set.
module tb_uart_tx_core;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit k is the k-th bit on the wire without parity
    logic       par;    // even parity of data
  } vec_t;

  logic       core_clk = 1'b0;
  logic       core_rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, ser_tx, tx_busy, tx_done;

  always #5 core_clk = ~core_clk;

  uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_tx(ser_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

`ifdef UART_TX_PARITY_EN
  logic rdy_odd, ser_odd, busy_odd, done_odd;
  uart_tx_core #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
    .core_clk(core_clk), .core_rst(core_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_odd), .ser_tx(ser_odd), .tx_busy(busy_odd), .tx_done(done_odd)
  );
`endif

  int   n_pass = 0;
  int   n_tot  = 0;
  logic ser_a  [1:256];
  logic rdy_a  [1:256];
  logic done_a [1:256];
  logic busy_a [1:256];
  logic odd_a  [1:256];
  vec_t vecs   [0:4];

  task automatic check_b(input string name, input logic got, input logic exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic check_v(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic exp_bit(input vec_t v, input int k, input logic odd);
    if (k < 9) return v.frame[k];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return v.par ^ odd;
`endif
    return 1'b1;
  endfunction

  task automatic handshake(input logic [7:0] d);
    int w = 0;
    @(negedge core_clk);
    while (!tx_ready && w < 100) begin
      @(negedge core_clk);
      w++;
    end
    check_b("ready_wait", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge core_clk);
  endtask

  // mode 0 plain, 1 data change while busy, 2 back-to-back, 3 reset during data bit 3
  task automatic capture(input int n, input int mode);
    for (int c = 1; c <= n; c++) begin
      @(negedge core_clk);
      ser_a[c]  = ser_tx;
      rdy_a[c]  = tx_ready;
      done_a[c] = tx_done;
      busy_a[c] = tx_busy;
`ifdef UART_TX_PARITY_EN
      odd_a[c]  = ser_odd;
`else
      odd_a[c]  = 1'b1;
`endif
      case (mode)
        1: begin
          if (c == 1) tx_valid = 1'b0;
          if (c == 10) begin tx_valid = 1'b1; tx_data = 8'hC3; end
          if (c == n) tx_valid = 1'b0;
        end
        2: begin
          if (c == 1) tx_data = 8'hFF;
          if (c == n) tx_valid = 1'b0;
        end
        3: begin
          if (c == 1) tx_valid = 1'b0;
          if (c == 18) core_rst = 1'b1;
          if (c == 19) core_rst = 1'b0;
        end
        default: if (c == 1) tx_valid = 1'b0;
      endcase
    end
  endtask

  task automatic check_frame(input string name, input int base, input vec_t v);
    logic [31:0] got = '0;
    logic [31:0] exp = '0;
    for (int k = 0; k < NB; k++) begin
      got[k] = ser_a[base + k*CPB + 2];
      exp[k] = exp_bit(v, k, 1'b0);
    end
    check_v({name, "_bits"}, got, exp);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int ndone = 0;
    int nbad  = 0;
    handshake(v.data);
    capture(FL, 0);
    check_frame(name, 0, v);
    for (int c = 1; c <= FL; c++) begin
      if (done_a[c]) ndone++;
      if (rdy_a[c] !== (c == FL)) nbad++;
    end
    check_b({name, "_start_latency"}, ser_a[1], 1'b0);
    check_b({name, "_busy"}, busy_a[1], 1'b1);
    check_v({name, "_done_count"}, ndone, 1);
    check_b({name, "_done_last"}, done_a[FL], 1'b1);
    check_v({name, "_ready_profile"}, nbad, 0);
`ifdef UART_TX_PARITY_EN
    check_b({name, "_odd_parity"}, odd_a[9*CPB + 2], v.par ^ 1'b1);
`endif
    @(negedge core_clk);
    check_b({name, "_idle_busy"}, tx_busy, 1'b0);
  endtask

  initial begin
    int   ndone;
    int   nbad;
    vec_t v5a;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h07, 10'b1000001110, 1'b1};
    v5a     = '{8'h5A, 10'b1010110100, 1'b0};

    // reset state on the first cycle after the first reset edge
    core_rst = 1'b1;
    @(posedge core_clk);
    @(negedge core_clk);
    check_b("rst_ser", ser_tx, 1'b1);
    check_b("rst_ready", tx_ready, 1'b1);
    check_b("rst_busy", tx_busy, 1'b0);
    check_b("rst_done", tx_done, 1'b0);
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // back-to-back 0x00 then 0xFF with tx_valid held high
    handshake(8'h00);
    capture(2*FL, 2);
    check_frame("b2b_first", 0, vecs[1]);
    check_frame("b2b_second", FL, vecs[2]);
    check_b("b2b_last_stop", ser_a[FL], 1'b1);
    check_b("b2b_no_gap", ser_a[FL+1], 1'b0);
    ndone = 0;
    for (int c = 1; c <= 2*FL; c++) if (done_a[c]) ndone++;
    check_v("b2b_done_count", ndone, 2);
    check_b("b2b_done_1", done_a[FL], 1'b1);
    check_b("b2b_done_2", done_a[2*FL], 1'b1);
    @(negedge core_clk);
    check_b("b2b_idle", tx_busy, 1'b0);

    // tx_data changes while busy
    handshake(8'h5A);
    capture(FL, 1);
    check_frame("chg", 0, v5a);
    nbad = 0;
    for (int c = 1; c <= FL; c++) if (rdy_a[c] !== (c == FL)) nbad++;
    check_v("chg_ready_profile", nbad, 0);
    check_b("chg_done", done_a[FL], 1'b1);
    @(negedge core_clk);
    check_b("chg_idle", tx_busy, 1'b0);

    // reset pulse during data bit 3, then a clean frame
    handshake(8'hA5);
    capture(FL, 3);
    check_b("rstmid_ser", ser_a[19], 1'b1);
    check_b("rstmid_busy", busy_a[19], 1'b0);
    ndone = 0;
    for (int c = 1; c <= FL; c++) if (done_a[c]) ndone++;
    check_v("rstmid_no_done", ndone, 0);
    run_vec("after_rst", vecs[3]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
